// File: rtl/ascon_pkg.sv
// Shared Ascon definitions: state geometry, permutation FSM encoding and round constants.
package ascon_pkg;

  localparam int ASCON_STATE_W    = 320;
  localparam int ASCON_WORD_W     = 64;
  localparam int ASCON_MAX_ROUNDS = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } perm_state_e;

  // Constant index 0 is the first round of p12; p^b starts part-way into the sequence.
  function automatic logic [7:0] ascon_rc(input logic [3:0] idx);
    return {4'hF - idx, idx};
  endfunction

endpackage

// File: rtl/ascon_round_function.sv
// One combinational Ascon round: constant addition, 5-bit S-box layer, linear diffusion.
// Sbox debug outputs exist only when ASCON_PERM_SBOX_TAP_EN is defined.
module ascon_round_function
  import ascon_pkg::*;
(
  input  logic [ASCON_STATE_W-1:0] state_in,
  input  logic [7:0]               rc,
`ifdef ASCON_PERM_SBOX_TAP_EN
  output logic [ASCON_STATE_W-1:0] sbox_in,
  output logic [ASCON_STATE_W-1:0] sbox_out,
`endif
  output logic [ASCON_STATE_W-1:0] state_out
);

  function automatic logic [ASCON_WORD_W-1:0] ror64(input logic [ASCON_WORD_W-1:0] x,
                                                    input int n);
    return (x >> n) | (x << (ASCON_WORD_W - n));
  endfunction

  logic [ASCON_WORD_W-1:0] a0, a1, a2, a3, a4;
  logic [ASCON_WORD_W-1:0] b0, b1, b2, b3, b4;
  logic [ASCON_WORD_W-1:0] c0, c1, c2, c3, c4;
  logic [ASCON_WORD_W-1:0] s0, s1, s2, s3, s4;
  logic [ASCON_WORD_W-1:0] l0, l1, l2, l3, l4;

  // The round constant only touches the low byte of x2.
  assign a0 = state_in[319:256];
  assign a1 = state_in[255:192];
  assign a2 = state_in[191:128] ^ {56'd0, rc};
  assign a3 = state_in[127:64];
  assign a4 = state_in[63:0];

  assign b0 = a0 ^ a4;
  assign b1 = a1;
  assign b2 = a2 ^ a1;
  assign b3 = a3;
  assign b4 = a4 ^ a3;

  assign c0 = b0 ^ (~b1 & b2);
  assign c1 = b1 ^ (~b2 & b3);
  assign c2 = b2 ^ (~b3 & b4);
  assign c3 = b3 ^ (~b4 & b0);
  assign c4 = b4 ^ (~b0 & b1);

  assign s0 = c0 ^ c4;
  assign s1 = c1 ^ c0;
  assign s2 = ~c2;
  assign s3 = c3 ^ c2;
  assign s4 = c4;

  assign l0 = s0 ^ ror64(s0, 19) ^ ror64(s0, 28);
  assign l1 = s1 ^ ror64(s1, 61) ^ ror64(s1, 39);
  assign l2 = s2 ^ ror64(s2, 1)  ^ ror64(s2, 6);
  assign l3 = s3 ^ ror64(s3, 10) ^ ror64(s3, 17);
  assign l4 = s4 ^ ror64(s4, 7)  ^ ror64(s4, 41);

  assign state_out = {l0, l1, l2, l3, l4};

`ifdef ASCON_PERM_SBOX_TAP_EN
  assign sbox_in  = {a0, a1, a2, a3, a4};
  assign sbox_out = {s0, s1, s2, s3, s4};
`endif

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Ascon p^a / p^b sequencer: one round per clock through a single round datapath.
// Define ASCON_PERM_SBOX_TAP_EN to add registered sbox capture taps.
module ascon_perm_ctrl
  import ascon_pkg::*;
#(
  parameter int MAX_ROUNDS = ASCON_MAX_ROUNDS,
  parameter int RCNT_W     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [RCNT_W-1:0]        num_rounds,
  input  logic [ASCON_STATE_W-1:0] state_in,
  output logic                     busy,
  output logic                     done,
  output logic [ASCON_STATE_W-1:0] state_out,
  output logic [RCNT_W-1:0]        round_idx
`ifdef ASCON_PERM_SBOX_TAP_EN
  ,
  output logic                     tap_valid,
  output logic [ASCON_STATE_W-1:0] tap_sbox_in,
  output logic [ASCON_STATE_W-1:0] tap_sbox_out
`endif
);

  // Handshake: start is a single-cycle request, honoured only when the FSM is in
  // IDLE or DONE; a start seen during RUN is dropped. done pulses for one cycle.
  localparam logic [RCNT_W-1:0] MAX_R = RCNT_W'(MAX_ROUNDS);
  localparam logic [RCNT_W-1:0] LAST  = RCNT_W'(MAX_ROUNDS - 1);

  perm_state_e              st_q, st_d;
  logic [ASCON_STATE_W-1:0] state_q, state_d;
  logic [RCNT_W-1:0]        idx_q, idx_d;
  logic [RCNT_W-1:0]        r_eff;
  logic [ASCON_STATE_W-1:0] round_out;
  logic [7:0]               rc;

  assign rc = ascon_rc(idx_q[3:0]);

`ifdef ASCON_PERM_SBOX_TAP_EN
  logic [ASCON_STATE_W-1:0] sbox_in_w, sbox_out_w;

  ascon_round_function u_round (
    .state_in  (state_q),
    .rc        (rc),
    .sbox_in   (sbox_in_w),
    .sbox_out  (sbox_out_w),
    .state_out (round_out)
  );

  // Taps are captured on the same edge that commits the round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_valid    <= 1'b0;
      tap_sbox_in  <= '0;
      tap_sbox_out <= '0;
    end else begin
      tap_valid <= (st_q == ST_RUN);
      if (st_q == ST_RUN) begin
        tap_sbox_in  <= sbox_in_w;
        tap_sbox_out <= sbox_out_w;
      end
    end
  end
`else
  ascon_round_function u_round (
    .state_in  (state_q),
    .rc        (rc),
    .state_out (round_out)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= ST_IDLE;
      state_q <= '0;
      idx_q   <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    idx_d   = idx_q;
    r_eff   = (num_rounds > MAX_R) ? MAX_R : num_rounds;
    case (st_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = state_in;
          idx_d   = MAX_R - r_eff;
          st_d    = (r_eff == '0) ? ST_DONE : ST_RUN;
        end else if (st_q == ST_DONE) begin
          st_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        state_d = round_out;
        if (idx_q == LAST) st_d = ST_DONE;
        else               idx_d = idx_q + RCNT_W'(1);
      end
      default: st_d = ST_IDLE;
    endcase
  end

  assign busy      = (st_q == ST_RUN);
  assign done      = (st_q == ST_DONE);
  assign state_out = state_q;
  assign round_idx = idx_q;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Self-checking bench for ascon_perm_ctrl against a table-driven Ascon permutation model.
module tb_ascon_perm_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   num_rounds = '0;
  logic [319:0] state_in = '0;
  logic         busy, done;
  logic [319:0] state_out;
  logic [3:0]   round_idx;

  int checks   = 0;
  int failures = 0;

  ascon_perm_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_rounds (num_rounds),
    .state_in   (state_in),
    .busy       (busy),
    .done       (done),
    .state_out  (state_out),
    .round_idx  (round_idx)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Ascon 5-bit S-box lookup, input/output bit 4 = x0 ... bit 0 = x4.
  logic [4:0] sbox_t [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                              5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                              5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                              5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  function automatic logic [319:0] model_round(input logic [319:0] s, input int ci);
    logic [63:0] x [5];
    logic [4:0]  col, o;
    for (int w = 0; w < 5; w++) x[w] = s[319 - 64*w -: 64];
    x[2] = x[2] ^ 64'(((15 - ci) * 16) + ci);
    for (int j = 0; j < 64; j++) begin
      col = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
      o   = sbox_t[col];
      for (int w = 0; w < 5; w++) x[w][j] = o[4 - w];
    end
    x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
    x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
    x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
    x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
    x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic int clamp(input int nr);
    return (nr > 12) ? 12 : nr;
  endfunction

  function automatic logic [319:0] model_perm(input logic [319:0] s, input int nr);
    logic [319:0] t;
    int r;
    t = s;
    r = clamp(nr);
    for (int i = 0; i < r; i++) t = model_round(t, 12 - r + i);
    return t;
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] s;
    for (int i = 0; i < 10; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Called at a negedge: presents start for exactly one rising edge.
  task automatic launch(input int nr, input logic [319:0] st);
    start      = 1'b1;
    num_rounds = 4'(nr);
    state_in   = st;
    @(negedge clk);
    start      = 1'b0;
    state_in   = rand_state();
  endtask

  // Starts at the negedge of the first cycle after acceptance; returns at the
  // negedge where done is seen (or after the cycle budget expires).
  task automatic observe(input int nr, input logic [319:0] st, input int spur_k);
    int r, k, busy_cnt;
    bit seen;
    r = clamp(nr);
    busy_cnt = 0;
    seen = 1'b0;
    for (k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      check($sformatf("run_idx_r%0d_k%0d", r, k), 320'(round_idx), 320'(12 - r + k - 1));
      if (k == spur_k) begin
        start      = 1'b1;
        num_rounds = 4'd3;
      end
    end
    start = 1'b0;
    check($sformatf("done_seen_r%0d", r), 320'(seen), 320'(1));
    if (seen) begin
      check($sformatf("latency_r%0d", r), 320'(k), 320'(r + 1));
      check($sformatf("busy_cycles_r%0d", r), 320'(busy_cnt), 320'(r));
      check($sformatf("result_r%0d", r), state_out, model_perm(st, nr));
      check($sformatf("done_idx_r%0d", r), 320'(round_idx), 320'((r == 0) ? 12 : 11));
    end
  endtask

  // One cycle after done with no new start: back to IDLE, result held.
  task automatic post_done(input logic [319:0] exp);
    @(negedge clk);
    check("post_done_low", 320'(done), 320'(0));
    check("post_busy_low", 320'(busy), 320'(0));
    check("post_state_held", state_out, exp);
  endtask

  task automatic full_run(input int nr, input logic [319:0] st, input int spur_k);
    launch(nr, st);
    observe(nr, st, spur_k);
    post_done(model_perm(st, nr));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [319:0] s1, s2;
    int nr1, nr2;
    int extra_done;

    #12;
    check("rst_busy", 320'(busy), 320'(0));
    check("rst_done", 320'(done), 320'(0));
    check("rst_state", state_out, 320'(0));
    check("rst_idx", 320'(round_idx), 320'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed round counts, including clamping and zero rounds.
    full_run(12, '0, 0);
    full_run(6, rand_state(), 0);
    full_run(8, rand_state(), 0);
    s1 = rand_state();
    full_run(0, s1, 0);
    full_run(15, s1, 0);
    full_run(13, rand_state(), 0);

    // Start pulsed during RUN must be ignored.
    full_run(12, rand_state(), 3);

    // Back-to-back: new start in the DONE cycle.
    s1 = rand_state();
    s2 = rand_state();
    nr2 = $urandom_range(1, 12);
    launch(12, s1);
    observe(12, s1, 0);
    launch(nr2, s2);
    observe(nr2, s2, 0);
    post_done(model_perm(s2, nr2));

    // Asynchronous reset in the middle of a p12.
    s1 = rand_state();
    launch(12, s1);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 320'(busy), 320'(0));
    check("midrst_done", 320'(done), 320'(0));
    check("midrst_state", state_out, 320'(0));
    check("midrst_idx", 320'(round_idx), 320'(0));
    @(negedge clk);
    rst = 1'b0;
    extra_done = 0;
    repeat (16) begin
      @(negedge clk);
      if (done || busy) extra_done++;
    end
    check("midrst_no_done", 320'(extra_done), 320'(0));
    full_run(12, rand_state(), 0);

    // Randomized permutations, occasionally chained through DONE.
    for (int t = 0; t < 10; t++) begin
      nr1 = $urandom_range(0, 15);
      s1  = rand_state();
      launch(nr1, s1);
      observe(nr1, s1, 0);
      if ($urandom_range(0, 1) == 1) begin
        nr2 = $urandom_range(0, 15);
        s2  = rand_state();
        launch(nr2, s2);
        observe(nr2, s2, 0);
        post_done(model_perm(s2, nr2));
      end else begin
        post_done(model_perm(s1, nr1));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ascon_perm_ctrl.md
Name: ascon_perm_ctrl

Overview:
Sequencer for the single-round Ascon datapath (ASCON_ROUND_FUNCTION), running one round per clock to build the p^a / p^b permutation.
- Loads a 320-bit state on a start pulse.
- Generates the round-constant sequence for the requested round count.
- Iterates the state through one ASCON_ROUND_FUNCTION instance.
- Pulses done with the final state held on the output.
- Sits between the mode-level FSM (init / AD / plaintext / finalisation) and the round datapath.

Parameters:
- MAX_ROUNDS, 12, maximum permutation rounds; also the base of the constant index (index = MAX_ROUNDS - rounds + i).
- RCNT_W, 4, width of the round-count input and the internal round index.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a permutation; accepted only in IDLE or DONE.
- num_rounds  input  RCNT_W  rounds to execute; sampled with start.
- state_in  input  320  {x0,x1,x2,x3,x4}, x0 in [319:256]; sampled with start.
- busy  output  1  high while rounds are executing (RUN).
- done  output  1  one-cycle pulse when state_out holds the permutation result.
- state_out  output  320  state register; result is valid from the done cycle until the next accepted start.
- round_idx  output  RCNT_W  current constant index, for debug/trace.

Behaviour:
- Reset (asynchronous, any state): FSM=IDLE, state register=0, round index=0, busy=0, done=0, state_out=0. Reset mid-permutation abandons the operation; no done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - r_eff = min(num_rounds, MAX_ROUNDS).
  - State register <= state_in; round index <= MAX_ROUNDS - r_eff.
  - If r_eff=0, go to DONE. Otherwise go to RUN.
- RUN, each cycle:
  - State register <= round(state register, rc).
  - rc = {4'hF - idx[3:0], idx[3:0]}.
  - If idx = MAX_ROUNDS-1, go to DONE. Otherwise idx <= idx+1.
- DONE: done=1 for exactly this cycle.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back permutations, no bubble).
  - Otherwise go to IDLE.
- busy = (FSM==RUN). done = (FSM==DONE). start in RUN is ignored: no queueing, no error flag.
- Latency: start accepted at edge E0; rounds applied at edges E1..Er; done high during the cycle after Er, i.e. r+1 cycles after start.
  - r=0: done in the cycle after E0, with state_out = state_in.
- num_rounds > 12: clamped to 12.
- round_idx holds its last value in IDLE/DONE.
- Round datapath: purely combinational, one instance, inputs driven from the state register. The datapath's sbox/p debug outputs are left unconnected unless the optional feature is enabled.

Optional Feature:
- Macro: ASCON_PERM_SBOX_TAP_EN.
- Enabled, extra outputs (for power side-channel correlation capture):
  - tap_valid (1 bit): high for one cycle per RUN cycle.
  - tap_sbox_in (320 bits) and tap_sbox_out (320 bits): registered copies of the round datapath's sbox input and sbox output for that round.
  - Timing: taps update one cycle after the corresponding round edge. tap_valid is high during the r cycles following E1..Er.
  - All taps reset to 0.
- Disabled: taps and their registers do not exist. Core timing is identical either way.

Decomposition:
- Shared package ascon_pkg:
  - ASCON_STATE_W=320, ASCON_WORD_W=64, ASCON_MAX_ROUNDS=12.
  - FSM state enum (IDLE/RUN/DONE).
  - Function returning the round constant for a given index.
- Sub-module: ASCON_ROUND_FUNCTION is instantiated as-is; no new sub-module.
- Optional: ascon_rc_gen (index -> 8-bit constant) if not packaged as a function.

Test Plan:
- 12 rounds: num_rounds=12, state_in=0 -> rc sequence 0xF0,0xE1,0xD2,0xC3,0xB4,0xA5,0x96,0x87,0x78,0x69,0x5A,0x4B; done at cycle 13 after start; state_out matches the software Ascon p12 model.
- 6 rounds: num_rounds=6 -> constants 0x96,0x87,0x78,0x69,0x5A,0x4B; round_idx runs 6..11; done after 7 cycles; result matches model p6.
- 8 rounds: num_rounds=8 -> first rc=0xB4, last rc=0x4B; done after 9 cycles; busy high for exactly 8 cycles.
- Boundaries: num_rounds=0 -> done next cycle, state_out=state_in. num_rounds=15 -> behaves identically to 12.
- Handshake: start pulsed in cycle 3 of a p12 -> ignored, single done only. Start asserted in the DONE cycle -> new permutation begins with no idle cycle.
- Reset mid-run: rst asserted asynchronously at round 5 -> busy=0, done=0, state_out=0 immediately; no done after reset release; next start runs normally.
